// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP on open-drain SCL/SDA.
// Bus outputs are registered from next-state values so that they change together with the state.
module i2c_byte_master #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dn_start,
    input  logic [6:0] dn_addr,
    input  logic       dn_rw,
    input  logic [7:0] dn_wr_data,
    output logic [7:0] dn_rd_data,
    output logic       dn_busy,
    output logic       dn_done,
    output logic       dn_ACK_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int unsigned CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          err_q, err_d;
    logic          sda_s1_q, sda_s2_q;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick_c;
    logic          slot_end_c;

    assign tick_c     = (cnt_q == CW'(CLK_DIV - 1));
    assign slot_end_c = tick_c && (qtr_q == 2'd3);

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
            sda_s1_q  <= sda_i;
            sda_s2_q  <= sda_s1_q;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Next-state, slot timing and bus decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            cnt_d = tick_c ? '0 : cnt_q + CW'(1);
            if (tick_c) qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (dn_start) begin
                    state_d   = S_START;
                    shift_d   = {dn_addr, dn_rw};
                    wdata_d   = dn_wr_data;
                    rw_d      = dn_rw;
                    err_d     = 1'b0;
                    ack_err_d = 1'b0;
                    cnt_d     = '0;
                    qtr_d     = '0;
                    bit_d     = '0;
                end
            end
            S_START: if (slot_end_c) state_d = S_ADDR;
            S_ADDR: begin
                if (slot_end_c) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (slot_end_c) begin
                    if (sda_s2_q) begin
                        err_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                        if (!rw_q) shift_d = wdata_q;
                    end
                end
            end
            S_DATA: begin
                if (slot_end_c) begin
                    shift_d = {shift_q[6:0], rw_q ? sda_s2_q : 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_DATA_ACK;
                end
            end
            S_DATA_ACK: begin
                if (slot_end_c) begin
                    if (!rw_q && sda_s2_q) err_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: if (slot_end_c) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d    = 1'b1;
            ack_err_d = err_d;
            if (rw_q && !err_d) rd_data_d = shift_q;
        end

        // SCL low in q0,q1 of data/ACK slots; SDA only ever changes with the slot
        case (state_d)
            S_START: begin
                sda_oe_d = qtr_d[1];
                scl_oe_d = (qtr_d == 2'd3);
            end
            S_ADDR: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !shift_d[7];
            end
            S_DATA: begin
                scl_oe_d = !qtr_d[1];
                sda_oe_d = !rw_d && !shift_d[7];
            end
            S_ADDR_ACK, S_DATA_ACK: scl_oe_d = !qtr_d[1];
            S_STOP: begin
                scl_oe_d = (qtr_d == 2'd0);
                sda_oe_d = !qtr_d[1];
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign dn_rd_data   = rd_data_q;
    assign dn_busy      = busy_q;
    assign dn_done      = done_q;
    assign dn_ACK_error = ack_err_q;
    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;
endmodule
